// File: rtl/shift_request_scheduler.sv
// Two-requester round-robin scheduler for the shared barrel shifter.
// The winner's operands are held on the shifter inputs for SETTLE_CYCLES clocks,
// then the result is captured and returned over a valid/ready handshake.
module shift_request_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0Valid,
  output logic        Req0Ready,
  input  logic [31:0] Req0IR,
  input  logic [31:0] Req0Rm,
  input  logic [31:0] Req0Rs,
  input  logic        Req0Cin,
  input  logic        Req1Valid,
  output logic        Req1Ready,
  input  logic [31:0] Req1IR,
  input  logic [31:0] Req1Rm,
  input  logic [31:0] Req1Rs,
  input  logic        Req1Cin,
  output logic [31:0] ShIR,
  output logic [31:0] ShRm,
  output logic [31:0] ShRs,
  output logic        ShCin,
  input  logic [31:0] ShOut,
  input  logic        ShCout,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic        RespCout,
  output logic        RespId
);

  // A zero settle time is meaningless; it behaves as a single settle cycle.
  localparam int unsigned SettleEff = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [3:0]  CntLoad   = 4'(SettleEff - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic        rr_q;
  logic [3:0]  cnt_q;
  logic [31:0] sh_ir_q, sh_rm_q, sh_rs_q;
  logic        sh_cin_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic        resp_cout_q;
  logic        resp_id_q;

  logic        gnt0, gnt1, gnt_any;
  logic [31:0] ir_d, rm_d, rs_d;
  logic        cin_d;
  logic        bypass_d;

  // Grant decision and winner operand selection; grants only exist in IDLE and never during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !Reset) begin
      if (Req0Valid && Req1Valid) begin
        gnt0 = ~rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = Req0Valid;
        gnt1 = Req1Valid;
      end
    end
    gnt_any  = gnt0 | gnt1;
    ir_d     = gnt1 ? Req1IR  : Req0IR;
    rm_d     = gnt1 ? Req1Rm  : Req0Rm;
    rs_d     = gnt1 ? Req1Rs  : Req0Rs;
    cin_d    = gnt1 ? Req1Cin : Req0Cin;
    // Only data-processing register/immediate forms (IR[27:25] = 000/001) need the shifter.
    bypass_d = (ir_d[27:26] != 2'b00);
  end

  // Scheduler FSM with registered shifter drive and response outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      cnt_q        <= '0;
      sh_ir_q      <= '0;
      sh_rm_q      <= '0;
      sh_rs_q      <= '0;
      sh_cin_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_cout_q  <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            sh_ir_q   <= ir_d;
            sh_rm_q   <= rm_d;
            sh_rs_q   <= rs_d;
            sh_cin_q  <= cin_d;
            resp_id_q <= gnt1;
            rr_q      <= ~gnt1;
            cnt_q     <= CntLoad;
            if (bypass_d) begin
              resp_data_q  <= rm_d;
              resp_cout_q  <= cin_d;
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            resp_data_q  <= ShOut;
            resp_cout_q  <= ShCout;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (RespReady) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Req0Ready = gnt0;
  assign Req1Ready = gnt1;
  assign ShIR      = sh_ir_q;
  assign ShRm      = sh_rm_q;
  assign ShRs      = sh_rs_q;
  assign ShCin     = sh_cin_q;
  assign RespValid = resp_valid_q;
  assign RespData  = resp_data_q;
  assign RespCout  = resp_cout_q;
  assign RespId    = resp_id_q;

endmodule

// File: tb/tb_shift_request_scheduler.sv
// Bench for shift_request_scheduler: two instances (settle 1 and settle 4),
// directed scenarios with literal expectations, then randomized traffic checked
// every cycle against a transaction-level model.
module tb_shift_request_scheduler;

  localparam int unsigned NI = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0[NI], v1[NI], c0[NI], c1[NI], rdy0[NI], rdy1[NI];
  logic        shcin[NI], shcout[NI], rv[NI], rrdy[NI], rcout[NI], rid[NI];
  logic [31:0] ir0[NI], rm0[NI], rs0[NI], ir1[NI], rm1[NI], rs1[NI];
  logic [31:0] shir[NI], shrm[NI], shrs[NI], shout[NI], rdata[NI];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state: one outstanding transaction per instance, described by owner,
  // result and the absolute cycle from which its response is visible.
  bit          m_txn[NI], m_rr[NI], m_own[NI], m_g0[NI], m_g1[NI];
  int          m_resp_cyc[NI];
  logic [31:0] m_data[NI], m_shir[NI], m_shrm[NI], m_shrs[NI];
  logic        m_cout[NI], m_shcin[NI];

  // ARM operand-2 barrel shifter: returns {carry, result}.
  function automatic logic [32:0] arm_shift(input logic [31:0] ir, input logic [31:0] rm,
                                            input logic [31:0] rs, input logic cin);
    logic [63:0]        t;
    logic signed [63:0] ts;
    logic [31:0]        r;
    logic               c;
    logic [7:0]         amt;
    logic [4:0]         rot;
    if (ir[25]) begin
      rot = {ir[11:8], 1'b0};
      t   = {24'd0, ir[7:0], 24'd0, ir[7:0]} >> rot;
      r   = t[31:0];
      c   = (rot == 5'd0) ? cin : r[31];
    end else begin
      amt = ir[4] ? rs[7:0] : {3'b000, ir[11:7]};
      case (ir[6:5])
        2'b00: begin t = {32'd0, rm} << amt; r = t[31:0];  c = (amt == 0) ? cin : t[32]; end
        2'b01: begin t = {rm, 32'd0} >> amt; r = t[63:32]; c = (amt == 0) ? cin : t[31]; end
        2'b10: begin
          ts = $signed({rm, 32'd0}) >>> amt;
          r  = ts[63:32];
          c  = (amt == 0) ? cin : ts[31];
        end
        default: begin
          t = {rm, rm} >> amt[4:0];
          r = t[31:0];
          c = (amt == 0) ? cin : r[31];
        end
      endcase
    end
    return {c, r};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    shift_request_scheduler #(.SETTLE_CYCLES(g == 0 ? 1 : 4)) u_dut (
      .Clk(clk), .Reset(rst),
      .Req0Valid(v0[g]), .Req0Ready(rdy0[g]), .Req0IR(ir0[g]), .Req0Rm(rm0[g]),
      .Req0Rs(rs0[g]), .Req0Cin(c0[g]),
      .Req1Valid(v1[g]), .Req1Ready(rdy1[g]), .Req1IR(ir1[g]), .Req1Rm(rm1[g]),
      .Req1Rs(rs1[g]), .Req1Cin(c1[g]),
      .ShIR(shir[g]), .ShRm(shrm[g]), .ShRs(shrs[g]), .ShCin(shcin[g]),
      .ShOut(shout[g]), .ShCout(shcout[g]),
      .RespValid(rv[g]), .RespReady(rrdy[g]), .RespData(rdata[g]),
      .RespCout(rcout[g]), .RespId(rid[g])
    );
    assign {shcout[g], shout[g]} = arm_shift(shir[g], shrm[g], shrs[g], shcin[g]);
  end

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic rand_op(output logic [31:0] ir, output logic [31:0] rm,
                         output logic [31:0] rs, output logic cin);
    int sel;
    ir  = $urandom;
    rm  = $urandom;
    rs  = {24'd0, 8'($urandom_range(0, 40))};
    cin = 1'($urandom);
    sel = $urandom_range(0, 9);
    if (sel < 3)      ir[27:25] = 3'b000;
    else if (sel < 6) ir[27:25] = 3'b001;
    else              ir[27:25] = 3'($urandom);
  endtask

  // Model: evaluate the cycle, compare every output, then advance to the next edge.
  always @(negedge clk) begin
    logic        e0, e1, ev, byp;
    logic [31:0] sir, srm, srs;
    logic        scin;
    logic [32:0] sres;
    for (int k = 0; k < NI; k++) begin
      m_g0[k] = 1'b0;
      m_g1[k] = 1'b0;
      if (rst) begin
        m_txn[k] = 1'b0; m_rr[k] = 1'b0; m_own[k] = 1'b0;
        m_shir[k] = '0; m_shrm[k] = '0; m_shrs[k] = '0; m_shcin[k] = 1'b0;
        check($sformatf("u%0d.rst.ready0", k), rdy0[k], 0);
        check($sformatf("u%0d.rst.ready1", k), rdy1[k], 0);
        check($sformatf("u%0d.rst.respvalid", k), rv[k], 0);
        check($sformatf("u%0d.rst.respdata", k), rdata[k], 0);
        check($sformatf("u%0d.rst.respcout", k), rcout[k], 0);
        check($sformatf("u%0d.rst.respid", k), rid[k], 0);
        check($sformatf("u%0d.rst.shir", k), shir[k], 0);
        check($sformatf("u%0d.rst.shrm", k), shrm[k], 0);
        check($sformatf("u%0d.rst.shrs", k), shrs[k], 0);
        check($sformatf("u%0d.rst.shcin", k), shcin[k], 0);
      end else begin
        ev = m_txn[k] && (cyc >= m_resp_cyc[k]);
        e0 = 1'b0;
        e1 = 1'b0;
        if (!m_txn[k]) begin
          if (v0[k] && v1[k]) begin
            e0 = !m_rr[k];
            e1 = m_rr[k];
          end else begin
            e0 = v0[k];
            e1 = v1[k];
          end
        end
        check($sformatf("u%0d.ready0", k), rdy0[k], e0);
        check($sformatf("u%0d.ready1", k), rdy1[k], e1);
        check($sformatf("u%0d.respvalid", k), rv[k], ev);
        check($sformatf("u%0d.shir", k), shir[k], m_shir[k]);
        check($sformatf("u%0d.shrm", k), shrm[k], m_shrm[k]);
        check($sformatf("u%0d.shrs", k), shrs[k], m_shrs[k]);
        check($sformatf("u%0d.shcin", k), shcin[k], m_shcin[k]);
        if (ev) begin
          check($sformatf("u%0d.respdata", k), rdata[k], m_data[k]);
          check($sformatf("u%0d.respcout", k), rcout[k], m_cout[k]);
          check($sformatf("u%0d.respid", k), rid[k], m_own[k]);
        end
        if (e0 || e1) begin
          sir  = e1 ? ir1[k] : ir0[k];
          srm  = e1 ? rm1[k] : rm0[k];
          srs  = e1 ? rs1[k] : rs0[k];
          scin = e1 ? c1[k]  : c0[k];
          byp  = !(sir[27:25] inside {3'b000, 3'b001});
          m_g0[k] = e0; m_g1[k] = e1;
          m_txn[k] = 1'b1; m_own[k] = e1; m_rr[k] = !e1;
          m_shir[k] = sir; m_shrm[k] = srm; m_shrs[k] = srs; m_shcin[k] = scin;
          if (byp) begin
            m_data[k] = srm; m_cout[k] = scin; m_resp_cyc[k] = cyc + 1;
          end else begin
            sres = arm_shift(sir, srm, srs, scin);
            m_data[k] = sres[31:0]; m_cout[k] = sres[32];
            m_resp_cyc[k] = cyc + settle_of(k) + 1;
          end
        end else if (ev && rrdy[k]) begin
          m_txn[k] = 1'b0;
        end
      end
    end
    cyc++;
  end

  // Stimulus: directed scenarios, then randomized requester/consumer traffic.
  initial begin
    logic gexp;
    int   ngr;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      v0[k] = 0; v1[k] = 0; c0[k] = 0; c1[k] = 0; rrdy[k] = 0;
      ir0[k] = '0; rm0[k] = '0; rs0[k] = '0; ir1[k] = '0; rm1[k] = '0; rs1[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.respvalid", rv[0], 0);
    check("reset.ready0", rdy0[0], 0);

    // Settle-1 LSL #2 on u0 and settle-4 immediate rotate on u1, issued together.
    @(posedge clk); #1;
    v0[0] = 1; ir0[0] = 32'hE1A00102; rm0[0] = 32'd5; rrdy[0] = 1;
    v0[1] = 1; ir0[1] = 32'hE3A004FF; rm0[1] = 32'h0; rrdy[1] = 1;
    @(negedge clk);
    check("t1.ready0", rdy0[0], 1);
    check("t5.ready0", rdy0[1], 1);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin v0[0] = 0; v0[1] = 0; end
      @(negedge clk);
      if (c == 1) check("t1.early_valid", rv[0], 0);
      if (c == 2) begin
        check("t1.respvalid", rv[0], 1);
        check("t1.respdata", rdata[0], 32'h14);
        check("t1.respid", rid[0], 0);
      end
      if (c == 4) check("t5.early_valid", rv[1], 0);
      if (c == 5) begin
        check("t5.respvalid", rv[1], 1);
        check("t5.respdata", rdata[1], 32'hFF000000);
      end
    end

    // Load/store immediate on port 1 bypasses the shifter.
    @(posedge clk); #1;
    v1[0] = 1; ir1[0] = 32'hE5910000; rm1[0] = 32'h1234; c1[0] = 1;
    @(negedge clk);
    check("t3.ready1", rdy1[0], 1);
    @(posedge clk); #1 v1[0] = 0;
    @(negedge clk);
    check("t3.respvalid", rv[0], 1);
    check("t3.respdata", rdata[0], 32'h1234);
    check("t3.respcout", rcout[0], 1);
    check("t3.respid", rid[0], 1);

    // Consumer stalls in DONE while another port-0 request waits.
    @(posedge clk); #1;
    v0[0] = 1; ir0[0] = 32'hE1A00102; rm0[0] = 32'd7; rrdy[0] = 0;
    @(negedge clk);
    check("t4.grant", rdy0[0], 1);
    @(posedge clk); #1;
    ir0[0] = 32'hE5910000; rm0[0] = 32'hABCD; c0[0] = 0;
    @(negedge clk);
    check("t4.busy_ready", rdy0[0], 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t4.hold_valid", rv[0], 1);
      check("t4.hold_data", rdata[0], 32'h1C);
      check("t4.hold_ready", rdy0[0], 0);
    end
    @(posedge clk); #1 rrdy[0] = 1;
    @(negedge clk);
    check("t4.hs_ready", rdy0[0], 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4.regrant", rdy0[0], 1);
    check("t4.regrant_valid", rv[0], 0);
    @(posedge clk); #1 v0[0] = 0;
    @(negedge clk);
    check("t4.second_data", rdata[0], 32'hABCD);

    // Both ports held valid from reset: grants alternate starting at port 0.
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    v0[0] = 1; v1[0] = 1; ir0[0] = 32'hE1A00102; ir1[0] = 32'hE1A00102; rrdy[0] = 1;
    gexp = 1'b0;
    ngr  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rdy0[0] || rdy1[0]) begin
        check("t2.onehot", rdy0[0] & rdy1[0], 0);
        check("t2.port", rdy1[0], gexp);
        gexp = ~gexp;
        ngr++;
      end
      @(posedge clk); #1;
    end
    check("t2.grants", ngr, 4);
    v0[0] = 0; v1[0] = 0;

    // Reset in BUSY discards the pending result and re-arms the pointer.
    v0[1] = 1; v1[1] = 1; ir0[1] = 32'hE3A004FF; ir1[1] = 32'hE1A00102; rrdy[1] = 1;
    repeat (3) @(posedge clk);
    #1;
    v0[1] = 0; v1[1] = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("t6.ready0", rdy0[1], 0);
    check("t6.respvalid", rv[1], 0);
    check("t6.shir", shir[1], 0);
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t6.no_resp", rv[1], 0);
      @(posedge clk); #1;
    end
    v0[1] = 1; v1[1] = 1;
    @(negedge clk);
    check("t6.ptr_ready0", rdy0[1], 1);
    check("t6.ptr_ready1", rdy1[1], 0);
    @(posedge clk); #1 v0[1] = 0;

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      for (int k = 0; k < NI; k++) begin
        rrdy[k] = ($urandom_range(0, 99) < 60);
        if (m_g0[k] || (v0[k] && $urandom_range(0, 99) < 3)) v0[k] = 0;
        else if (!v0[k] && $urandom_range(0, 99) < 25) begin
          v0[k] = 1;
          rand_op(ir0[k], rm0[k], rs0[k], c0[k]);
        end
        if (m_g1[k] || (v1[k] && $urandom_range(0, 99) < 3)) v1[k] = 0;
        else if (!v1[k] && $urandom_range(0, 99) < 25) begin
          v1[k] = 1;
          rand_op(ir1[k], rm1[k], rs1[k], c1[k]);
        end
      end
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got no end, want end");
    $fatal(1, "timeout");
  end

endmodule
